// File: rtl/fifo_test_pkg.sv
// Shared definitions for the FIFO test path: FSM state encoding, pattern
// selectors and the LFSR step function used by the pattern generator.
package fifo_test_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  localparam int PAT_COUNTER = 0;
  localparam int PAT_LFSR    = 1;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/pattern_gen.sv
// Holds the current FIFO write word and steps it through the selected
// deterministic sequence (counter or LFSR) on each accepted write.
module pattern_gen
  import fifo_test_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                PATTERN = PAT_COUNTER,
  parameter logic [DATA_W-1:0] SEED    = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              clr,
  output logic [DATA_W-1:0] din
);

  logic [DATA_W-1:0] nxt;

  generate
    if (PATTERN == PAT_LFSR) begin : g_lfsr
      assign nxt = DATA_W'(lfsr_next(32'(din)));
    end else begin : g_cnt
      assign nxt = din + DATA_W'(1);
    end
  endgenerate

  // clr wins over adv: a run restart must always land on SEED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din <= SEED;
    end else if (clr) begin
      din <= SEED;
    end else if (adv) begin
      din <= nxt;
    end
  end

endmodule

// File: rtl/fifo_writer.sv
// Producer side of the FIFO test path: writes a deterministic pattern into the
// test FIFO in bursts, throttled by full/prog_full, while en is high.
module fifo_writer
  import fifo_test_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                BURST_LEN   = 256,
  parameter int unsigned       TOTAL_WORDS = 0,
  parameter int                PATTERN     = PAT_COUNTER,
  parameter logic [DATA_W-1:0] SEED        = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              full,
  input  logic              prog_full,
  output logic              wr_en,
  output logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic [31:0]       word_cnt,
  output logic [1:0]        state_dbg
);

  localparam logic [31:0] LAST_WORD   = 32'(TOTAL_WORDS) - 32'd1;
  localparam logic [31:0] BURST_LAST  = 32'(BURST_LEN) - 32'd1;
  localparam bit          RUN_BOUNDED = (TOTAL_WORDS != 0);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] burst_cnt;
  logic        last_word;
  logic        burst_end;
  logic        clr_run;
  logic        burst_clr;

  // Handshake: a word is transferred on every rising edge where wr_en=1; din is
  // valid whenever wr_en is high. wr_en is a zero-latency gate on full, so a
  // full FIFO is never written and no ready/retry state is needed.
  assign wr_en     = (state == WRITE) & en & ~full;
  assign last_word = RUN_BOUNDED && (word_cnt == LAST_WORD);
  assign burst_end = (burst_cnt == BURST_LAST);
  assign clr_run   = (state == DONE) & ~en;
  assign state_dbg = state;

  // Priority: ~en > end of run > pause (burst end or prog_full).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (en) state_nxt = WRITE;
      WRITE: begin
        if (!en)                                    state_nxt = IDLE;
        else if (wr_en && last_word)                state_nxt = DONE;
        else if ((wr_en && burst_end) || prog_full) state_nxt = PAUSE;
      end
      PAUSE: begin
        if (!en)             state_nxt = IDLE;
        else if (!prog_full) state_nxt = WRITE;
      end
      DONE:  if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign burst_clr = ((state_nxt == IDLE)  && (state != IDLE)) ||
                     ((state_nxt == PAUSE) && (state == WRITE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      word_cnt  <= 32'd0;
      burst_cnt <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == WRITE) || (state_nxt == PAUSE);
      done  <= (state_nxt == DONE);

      // Leaving IDLE from WRITE/PAUSE keeps word_cnt so the run resumes.
      if (clr_run)    word_cnt <= 32'd0;
      else if (wr_en) word_cnt <= word_cnt + 32'd1;

      if (burst_clr)  burst_cnt <= 32'd0;
      else if (wr_en) burst_cnt <= burst_cnt + 32'd1;
    end
  end

  pattern_gen #(
    .DATA_W  (DATA_W),
    .PATTERN (PATTERN),
    .SEED    (SEED)
  ) u_pattern_gen (
    .clk (clk),
    .rst (rst),
    .adv (wr_en),
    .clr (clr_run),
    .din (din)
  );

endmodule

// File: tb/tb_fifo_writer.sv
// Bench for fifo_writer: three instances (bursting counter, bounded run, LFSR)
// with an expected-word queue per instance checked by a monitor on each write.
module tb_fifo_writer;
  import fifo_test_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        en_a, full_a, pf_a, wr_en_a, busy_a, done_a;
  logic [31:0] din_a, word_cnt_a;
  logic [1:0]  state_a;
  logic        en_b, full_b, pf_b, wr_en_b, busy_b, done_b;
  logic [31:0] din_b, word_cnt_b;
  logic [1:0]  state_b;
  logic        en_c, full_c, pf_c, wr_en_c, busy_c, done_c;
  logic [31:0] din_c, word_cnt_c;
  logic [1:0]  state_c;

  fifo_writer #(.DATA_W(32), .BURST_LEN(4), .TOTAL_WORDS(0), .PATTERN(PAT_COUNTER), .SEED(32'd1)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .full(full_a), .prog_full(pf_a), .wr_en(wr_en_a),
    .din(din_a), .busy(busy_a), .done(done_a), .word_cnt(word_cnt_a), .state_dbg(state_a));

  fifo_writer #(.DATA_W(32), .BURST_LEN(256), .TOTAL_WORDS(5), .PATTERN(PAT_COUNTER), .SEED(32'd1)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .full(full_b), .prog_full(pf_b), .wr_en(wr_en_b),
    .din(din_b), .busy(busy_b), .done(done_b), .word_cnt(word_cnt_b), .state_dbg(state_b));

  fifo_writer #(.DATA_W(32), .BURST_LEN(256), .TOTAL_WORDS(0), .PATTERN(PAT_LFSR), .SEED(32'd1)) u_c (
    .clk(clk), .rst(rst), .en(en_c), .full(full_c), .prog_full(pf_c), .wr_en(wr_en_c),
    .din(din_c), .busy(busy_c), .done(done_c), .word_cnt(word_cnt_c), .state_dbg(state_c));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: write of %h seen, expected no write", name, act);
  endtask

  always @(negedge clk) begin
    if (wr_en_a === 1'b1) begin
      if (qa.size() == 0) unexpected("mon_a", din_a);
      else check("mon_a_din", din_a, qa.pop_front());
    end
    if (wr_en_b === 1'b1) begin
      if (qb.size() == 0) unexpected("mon_b", din_b);
      else check("mon_b_din", din_b, qb.pop_front());
    end
    if (wr_en_c === 1'b1) begin
      if (qc.size() == 0) unexpected("mon_c", din_c);
      else check("mon_c_din", din_c, qc.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  bit we_free[10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
  bit full_bp[8]  = '{0, 0, 0, 1, 1, 1, 0, 0};
  bit we_bp[8]    = '{0, 1, 1, 0, 0, 0, 1, 1};
  bit pf_pf[10]   = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
  bit we_pf[10]   = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 1};
  bit we_run[8]   = '{0, 1, 1, 1, 1, 1, 0, 0};

  initial begin
    rst = 1'b1;
    en_a = 0; full_a = 0; pf_a = 0;
    en_b = 0; full_b = 0; pf_b = 0;
    en_c = 0; full_c = 0; pf_c = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", 32'(wr_en_a), 32'd0);
    check("rst_din", din_a, 32'd1);
    check("rst_word_cnt", word_cnt_a, 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_b), 32'd0);
    check("rst_state", 32'(state_a), 32'(IDLE));
    rst = 1'b0;
    step();

    // Free run: 1..4, one PAUSE cycle, 5..8.
    for (int v = 1; v <= 8; v++) qa.push_back(32'(v));
    en_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("free_we%0d", i), 32'(wr_en_a), 32'(we_free[i]));
      step();
    end
    check("free_state_pause", 32'(state_a), 32'(PAUSE));
    check("free_word_cnt", word_cnt_a, 32'd8);
    check("free_busy", 32'(busy_a), 32'd1);
    en_a = 1'b0;
    step();
    check("free_idle", 32'(state_a), 32'(IDLE));
    check("free_din_kept", din_a, 32'd9);

    // Backpressure: full for 3 cycles mid-burst.
    for (int v = 9; v <= 12; v++) qa.push_back(32'(v));
    en_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      full_a = full_bp[i];
      @(negedge clk);
      check($sformatf("bp_we%0d", i), 32'(wr_en_a), 32'(we_bp[i]));
      if (full_bp[i]) check($sformatf("bp_state%0d", i), 32'(state_a), 32'(WRITE));
      step();
    end
    full_a = 1'b0;
    check("bp_word_cnt", word_cnt_a, 32'd12);
    check("bp_state_pause", 32'(state_a), 32'(PAUSE));
    en_a = 1'b0;
    step();

    // prog_full raised during the write of 14: that write lands, then PAUSE.
    for (int v = 13; v <= 18; v++) qa.push_back(32'(v));
    en_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pf_a = pf_pf[i];
      @(negedge clk);
      check($sformatf("pf_we%0d", i), 32'(wr_en_a), 32'(we_pf[i]));
      if (i == 3) check("pf_state_pause", 32'(state_a), 32'(PAUSE));
      step();
    end
    check("pf_word_cnt", word_cnt_a, 32'd18);
    en_a = 1'b0;
    step();

    // Reset mid-burst, then restart from SEED.
    qa.push_back(32'd19);
    qa.push_back(32'd20);
    en_a = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    check("mrst_wr_en", 32'(wr_en_a), 32'd0);
    check("mrst_din", din_a, 32'd1);
    check("mrst_word_cnt", word_cnt_a, 32'd0);
    check("mrst_busy", 32'(busy_a), 32'd0);
    check("mrst_state", 32'(state_a), 32'(IDLE));
    step();
    rst = 1'b0;
    qa.push_back(32'd1);
    qa.push_back(32'd2);
    step();
    step();
    step();
    en_a = 1'b0;
    #1;
    check("en_drop_gate", 32'(wr_en_a), 32'd0);
    check("en_drop_state", 32'(state_a), 32'(WRITE));
    step();
    check("en_drop_idle", 32'(state_a), 32'(IDLE));
    check("en_drop_word_cnt", word_cnt_a, 32'd2);

    // Bounded run of 5 words, done, clear, repeat identically.
    for (int rep = 0; rep < 2; rep++) begin
      for (int v = 1; v <= 5; v++) qb.push_back(32'(v));
      en_b = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check($sformatf("run%0d_we%0d", rep, i), 32'(wr_en_b), 32'(we_run[i]));
        step();
      end
      check("run_done", 32'(done_b), 32'd1);
      check("run_busy", 32'(busy_b), 32'd0);
      check("run_word_cnt", word_cnt_b, 32'd5);
      check("run_state", 32'(state_b), 32'(DONE));
      en_b = 1'b0;
      step();
      check("run_clr_state", 32'(state_b), 32'(IDLE));
      check("run_clr_done", 32'(done_b), 32'd0);
      check("run_clr_din", din_b, 32'd1);
      check("run_clr_word_cnt", word_cnt_b, 32'd0);
    end

    // LFSR sequence from SEED=1.
    qc.push_back(32'h0000_0001);
    qc.push_back(32'h8020_0003);
    qc.push_back(32'hC030_0002);
    en_c = 1'b1;
    repeat (4) step();
    en_c = 1'b0;
    #1;
    check("lfsr_gate", 32'(wr_en_c), 32'd0);
    step();
    check("lfsr_word_cnt", word_cnt_c, 32'd3);
    check("lfsr_din_next", din_c, 32'h6018_0001);

    step();
    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);
    check("qc_drained", 32'(qc.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
